// File: rtl/accel_mem_bridge_pkg.sv
// Shared types and sizing helpers for the accelerator-to-memory bridge.
// Holds the read-path state encoding and the FIFO entry / timeout counter widths.
package accel_mem_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_RD_REQ  = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_RD_RESP = 3'd4
    } bridge_state_t;

    localparam int DEF_ADDR_W      = 32;
    localparam int DEF_DATA_W      = 64;
    localparam int DEF_TIMEOUT     = 1024;

    // A posted write is stored as {address, writedata, byteenable}.
    function automatic int entry_width(input int aw, input int dw);
        return aw + dw + dw / 8;
    endfunction

    function automatic int tmo_cnt_width(input int t);
        return (t < 2) ? 1 : $clog2(t);
    endfunction

    localparam int ENTRY_W   = entry_width(DEF_ADDR_W, DEF_DATA_W);
    localparam int TMO_CNT_W = tmo_cnt_width(DEF_TIMEOUT);

endpackage

// File: rtl/accel_bridge_wfifo.sv
// Posted-write FIFO: synchronous, power-of-two depth, head read straight from storage.
// The caller never pushes when full nor pops when empty.
module accel_bridge_wfifo
    import accel_mem_bridge_pkg::*;
#(
    parameter int WIDTH = ENTRY_W,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, 1'b1};
        if (pop_i)  rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, 1'b1};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q[PTR_W-1:0]] <= data_i;
    end

endmodule

// File: rtl/accel_mem_bridge.sv
// Bridges the accelerator's held-read/waitrequest master onto a pipelined memory master:
// writes are posted through a FIFO, reads wait for the FIFO to drain and can time out.
module accel_mem_bridge
    import accel_mem_bridge_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 64,
    parameter int WFIFO_DEPTH    = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                csi_clockreset_clk,
    input  logic                csi_clockreset_reset,
    input  logic [ADDR_W-1:0]   avs_acc_address,
    input  logic [DATA_W-1:0]   avs_acc_writedata,
    input  logic [DATA_W/8-1:0] avs_acc_byteenable,
    input  logic                avs_acc_write,
    input  logic                avs_acc_read,
    output logic [DATA_W-1:0]   avs_acc_readdata,
    output logic                avs_acc_waitrequest,
    output logic [ADDR_W-1:0]   avm_mem_address,
    output logic [DATA_W-1:0]   avm_mem_writedata,
    output logic [DATA_W/8-1:0] avm_mem_byteenable,
    output logic                avm_mem_write,
    output logic                avm_mem_read,
    input  logic                avm_mem_waitrequest,
    input  logic [DATA_W-1:0]   avm_mem_readdata,
    input  logic                avm_mem_readdatavalid,
    output logic                rd_timeout
);

    localparam int BE_W  = DATA_W / 8;
    localparam int EW    = entry_width(ADDR_W, DATA_W);
    localparam int CNT_W = tmo_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    bridge_state_t     state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [BE_W-1:0]   rd_be_q, rd_be_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              tmo_q, tmo_d;

    logic              fifo_full, fifo_empty, wr_accept, fifo_pop;
    logic [EW-1:0]     fifo_head;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [BE_W-1:0]   head_be;

    // Writes are only taken in IDLE, so a read never overtakes a posted write.
    assign wr_accept = avs_acc_write && !fifo_full && (state_q == ST_IDLE);
    assign fifo_pop  = !fifo_empty && !avm_mem_waitrequest;

    accel_bridge_wfifo #(
        .WIDTH (EW),
        .DEPTH (WFIFO_DEPTH)
    ) u_wfifo (
        .clk_i   (csi_clockreset_clk),
        .rst_i   (csi_clockreset_reset),
        .push_i  (wr_accept),
        .data_i  ({avs_acc_address, avs_acc_writedata, avs_acc_byteenable}),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head_addr = fifo_head[EW-1 -: ADDR_W];
    assign head_data = fifo_head[DATA_W+BE_W-1 -: DATA_W];
    assign head_be   = fifo_head[BE_W-1:0];

    assign avs_acc_waitrequest = !(wr_accept || (state_q == ST_RD_RESP));
    assign avs_acc_readdata    = rdata_q;
    assign rd_timeout          = tmo_q;
    assign avm_mem_write       = !fifo_empty;
    assign avm_mem_read        = (state_q == ST_RD_REQ);

    // The FIFO is always empty in RD_REQ, so the two sources never collide.
    always_comb begin
        avm_mem_address    = '0;
        avm_mem_writedata  = '0;
        avm_mem_byteenable = '0;
        if (!fifo_empty) begin
            avm_mem_address    = head_addr;
            avm_mem_writedata  = head_data;
            avm_mem_byteenable = head_be;
        end else if (state_q == ST_RD_REQ) begin
            avm_mem_address    = rd_addr_q;
            avm_mem_byteenable = rd_be_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        rd_be_d   = rd_be_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        tmo_d     = tmo_q;
        case (state_q)
            ST_IDLE: begin
                if (avs_acc_read && !avs_acc_write) begin
                    rd_addr_d = avs_acc_address;
                    rd_be_d   = avs_acc_byteenable;
                    state_d   = fifo_empty ? ST_RD_REQ : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) state_d = ST_RD_REQ;
            end
            ST_RD_REQ: begin
                if (!avm_mem_waitrequest) begin
                    state_d = ST_RD_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_RD_WAIT: begin
                if (avm_mem_readdatavalid) begin
                    rdata_d = avm_mem_readdata;
                    state_d = ST_RD_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    tmo_d   = 1'b1;
                    state_d = ST_RD_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RD_RESP: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge csi_clockreset_clk or posedge csi_clockreset_reset) begin
        if (csi_clockreset_reset) begin
            state_q   <= ST_IDLE;
            rd_addr_q <= '0;
            rd_be_q   <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            rd_be_q   <= rd_be_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            tmo_q     <= tmo_d;
        end
    end

endmodule

// File: tb/tb_accel_mem_bridge.sv
// Directed bench for accel_mem_bridge with a small variable-latency memory model.
// Each scenario task drives the accelerator side and checks hand-computed results.
module tb_accel_mem_bridge;

    localparam int AW  = 32;
    localparam int DW  = 64;
    localparam int BW  = 8;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] avs_acc_address = '0;
    logic [DW-1:0] avs_acc_writedata = '0;
    logic [BW-1:0] avs_acc_byteenable = '0;
    logic          avs_acc_write = 1'b0;
    logic          avs_acc_read = 1'b0;
    logic [DW-1:0] avs_acc_readdata;
    logic          avs_acc_waitrequest;
    logic [AW-1:0] avm_mem_address;
    logic [DW-1:0] avm_mem_writedata;
    logic [BW-1:0] avm_mem_byteenable;
    logic          avm_mem_write;
    logic          avm_mem_read;
    logic          avm_mem_waitrequest = 1'b0;
    logic [DW-1:0] avm_mem_readdata = '0;
    logic          avm_mem_readdatavalid = 1'b0;
    logic          rd_timeout;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    accel_mem_bridge #(
        .ADDR_W(AW), .DATA_W(DW), .WFIFO_DEPTH(4), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .csi_clockreset_clk   (clk),
        .csi_clockreset_reset (rst),
        .avs_acc_address      (avs_acc_address),
        .avs_acc_writedata    (avs_acc_writedata),
        .avs_acc_byteenable   (avs_acc_byteenable),
        .avs_acc_write        (avs_acc_write),
        .avs_acc_read         (avs_acc_read),
        .avs_acc_readdata     (avs_acc_readdata),
        .avs_acc_waitrequest  (avs_acc_waitrequest),
        .avm_mem_address      (avm_mem_address),
        .avm_mem_writedata    (avm_mem_writedata),
        .avm_mem_byteenable   (avm_mem_byteenable),
        .avm_mem_write        (avm_mem_write),
        .avm_mem_read         (avm_mem_read),
        .avm_mem_waitrequest  (avm_mem_waitrequest),
        .avm_mem_readdata     (avm_mem_readdata),
        .avm_mem_readdatavalid(avm_mem_readdatavalid),
        .rd_timeout           (rd_timeout)
    );

    // Memory model: rd_lat cycles from read acceptance to readdatavalid, 0 = never responds.
    logic [DW-1:0]       mem_arr [logic [AW-1:0]];
    logic [AW+DW+BW-1:0] wr_log[$];
    int                  rd_lat = 1;
    int                  pend_cnt = 0;
    logic [AW-1:0]       pend_addr = '0;
    int                  last_wr_cyc = 0;
    int                  last_rd_cyc = 0;
    int                  strobe_cnt = 0;

    always @(posedge clk) begin : mem_model
        logic [DW-1:0] cur;
        logic          fire;
        fire = 1'b0;
        if (avm_mem_write && !avm_mem_waitrequest) begin
            wr_log.push_back({avm_mem_address, avm_mem_writedata, avm_mem_byteenable});
            cur = mem_arr.exists(avm_mem_address) ? mem_arr[avm_mem_address] : '0;
            for (int i = 0; i < BW; i++)
                if (avm_mem_byteenable[i]) cur[8*i +: 8] = avm_mem_writedata[8*i +: 8];
            mem_arr[avm_mem_address] = cur;
            last_wr_cyc = cyc;
            strobe_cnt++;
        end
        if (avm_mem_read && !avm_mem_waitrequest) begin
            pend_addr   = avm_mem_address;
            pend_cnt    = rd_lat;
            last_rd_cyc = cyc;
            strobe_cnt++;
        end
        if (pend_cnt > 0) begin
            pend_cnt--;
            fire = (pend_cnt == 0);
        end
        #1;
        avm_mem_readdatavalid = fire;
        if (fire) avm_mem_readdata = mem_arr.exists(pend_addr) ? mem_arr[pend_addr] : '0;
        else      avm_mem_readdata = 64'hBADC_0FFE_E0DD_F00D;
    end

    always @(negedge clk) begin
        if (avm_mem_read && avm_mem_write) begin
            tests_failed++;
            $display("FAIL mem_strobe_overlap: read=%b write=%b, required never both", avm_mem_read, avm_mem_write);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic acc_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be,
                             input int budget, output int waited);
        avs_acc_address = a; avs_acc_writedata = d; avs_acc_byteenable = be; avs_acc_write = 1'b1;
        waited = 0;
        @(negedge clk);
        while (avs_acc_waitrequest && waited < budget) begin
            waited++;
            @(negedge clk);
        end
        if (avs_acc_waitrequest) begin
            tests_run++; tests_failed++;
            $display("FAIL write_accept_budget: addr %h still stalled after %0d cycles", a, budget);
        end
        step();
        avs_acc_write = 1'b0;
    endtask

    task automatic acc_read(input logic [AW-1:0] a, input int budget, output logic [DW-1:0] d,
                            output int cycles, output logic tmo);
        avs_acc_address = a; avs_acc_byteenable = 8'hFF; avs_acc_read = 1'b1;
        cycles = 0;
        @(negedge clk);
        while (avs_acc_waitrequest && cycles < budget) begin
            cycles++;
            @(negedge clk);
        end
        d = avs_acc_readdata;
        tmo = rd_timeout;
        if (avs_acc_waitrequest) begin
            tests_run++; tests_failed++;
            $display("FAIL read_response_budget: addr %h no response after %0d cycles", a, budget);
        end
        step();
        avs_acc_read = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++; if (avs_acc_waitrequest !== 1'b1) begin tests_failed++; $display("FAIL reset_waitreq: got %b want 1", avs_acc_waitrequest); end
        tests_run++; if (avs_acc_readdata !== '0) begin tests_failed++; $display("FAIL reset_readdata: got %h want 0", avs_acc_readdata); end
        tests_run++; if (avm_mem_write !== 1'b0 || avm_mem_read !== 1'b0) begin tests_failed++; $display("FAIL reset_strobes: got wr=%b rd=%b want 0 0", avm_mem_write, avm_mem_read); end
        tests_run++; if ({avm_mem_address, avm_mem_writedata, avm_mem_byteenable} !== '0) begin tests_failed++; $display("FAIL reset_mem_fields: got %h %h %h want 0", avm_mem_address, avm_mem_writedata, avm_mem_byteenable); end
        tests_run++; if (rd_timeout !== 1'b0) begin tests_failed++; $display("FAIL reset_rd_timeout: got %b want 0", rd_timeout); end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_write();
        int w;
        avm_mem_waitrequest = 1'b0;
        wr_log.delete();
        acc_write(32'h100, 64'h1122_3344_5566_7788, 8'hFF, 4, w);
        tests_run++; if (w != 0) begin tests_failed++; $display("FAIL single_write_accept: stalled %0d cycles want 0", w); end
        @(negedge clk);
        tests_run++; if (avm_mem_write !== 1'b1) begin tests_failed++; $display("FAIL single_write_strobe: got %b want 1", avm_mem_write); end
        tests_run++;
        if ({avm_mem_address, avm_mem_writedata, avm_mem_byteenable} !== {32'h100, 64'h1122_3344_5566_7788, 8'hFF}) begin
            tests_failed++;
            $display("FAIL single_write_fields: got %h %h %h want 100 1122334455667788 ff", avm_mem_address, avm_mem_writedata, avm_mem_byteenable);
        end
        step();
        @(negedge clk);
        tests_run++; if (avm_mem_write !== 1'b0) begin tests_failed++; $display("FAIL single_write_one_cycle: got %b want 0", avm_mem_write); end
        tests_run++; if (wr_log.size() != 1) begin tests_failed++; $display("FAIL single_write_count: got %0d want 1", wr_log.size()); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [AW+DW+BW-1:0] exp_q[$];
        logic [BW-1:0]       be_tab[5] = '{8'hFF, 8'h0F, 8'hF0, 8'h3C, 8'h81};
        logic [AW+DW+BW-1:0] got;
        int w;
        wr_log.delete();
        avm_mem_waitrequest = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({32'h400 + 32'(8*i), 64'(i + 1) * 64'h0101_0101_0101_0101, be_tab[i]});
            acc_write(32'h400 + 32'(8*i), 64'(i + 1) * 64'h0101_0101_0101_0101, be_tab[i], 2, w);
            tests_run++; if (w != 0) begin tests_failed++; $display("FAIL fill_accept_%0d: stalled %0d want 0", i, w); end
        end
        exp_q.push_back({32'h420, 64'h0505_0505_0505_0505, be_tab[4]});
        fork
            acc_write(32'h420, 64'h0505_0505_0505_0505, be_tab[4], 20, w);
            begin
                repeat (3) step();
                avm_mem_waitrequest = 1'b0;
            end
        join
        tests_run++; if (w != 4) begin tests_failed++; $display("FAIL full_stall_cycles: got %0d want 4", w); end
        repeat (8) step();
        tests_run++; if (wr_log.size() != 5) begin tests_failed++; $display("FAIL fill_write_count: got %0d want 5", wr_log.size()); end
        for (int i = 0; i < 5; i++) begin
            got = (i < wr_log.size()) ? wr_log[i] : '0;
            tests_run++; if (got !== exp_q[i]) begin tests_failed++; $display("FAIL fill_order_%0d: got %h want %h", i, got, exp_q[i]); end
        end
    endtask

    task automatic test_read_after_write();
        logic [DW-1:0] d;
        int            c, w;
        logic          t;
        wr_log.delete();
        rd_lat = 1;
        avm_mem_waitrequest = 1'b1;
        acc_write(32'h200, 64'hA5, 8'hFF, 2, w);
        tests_run++; if (w != 0) begin tests_failed++; $display("FAIL raw_write_accept: stalled %0d want 0", w); end
        fork
            acc_read(32'h200, 50, d, c, t);
            begin
                repeat (3) step();
                avm_mem_waitrequest = 1'b0;
            end
        join
        tests_run++; if (d !== 64'hA5) begin tests_failed++; $display("FAIL raw_data: got %h want a5", d); end
        tests_run++; if (last_rd_cyc <= last_wr_cyc) begin tests_failed++; $display("FAIL raw_order: read accepted cycle %0d, write cycle %0d, want read later", last_rd_cyc, last_wr_cyc); end
        tests_run++; if (c != 7) begin tests_failed++; $display("FAIL raw_latency: got %0d want 7", c); end
        step();
    endtask

    task automatic test_variable_latency();
        logic [DW-1:0] d;
        int            c;
        logic          t;
        mem_arr[32'h300] = 64'hDEAD_BEEF_CAFE_F00D;
        rd_lat = 7;
        acc_read(32'h300, 50, d, c, t);
        tests_run++; if (d !== 64'hDEAD_BEEF_CAFE_F00D) begin tests_failed++; $display("FAIL varlat_data: got %h want deadbeefcafef00d", d); end
        tests_run++; if (c != 9) begin tests_failed++; $display("FAIL varlat_cycles: got %0d want 9", c); end
        @(negedge clk);
        tests_run++; if (avs_acc_waitrequest !== 1'b1) begin tests_failed++; $display("FAIL varlat_one_cycle: waitreq got %b want 1", avs_acc_waitrequest); end
        step();
        rd_lat = 1;
        acc_read(32'h200, 20, d, c, t);
        tests_run++; if (d !== 64'hA5) begin tests_failed++; $display("FAIL minlat_data: got %h want a5", d); end
        tests_run++; if (c != 3) begin tests_failed++; $display("FAIL minlat_cycles: got %0d want 3", c); end
        step();
    endtask

    task automatic test_timeout();
        logic [DW-1:0] d;
        int            c;
        logic          t;
        rd_lat = 20;
        acc_read(32'h300, 40, d, c, t);
        tests_run++; if (d !== '0) begin tests_failed++; $display("FAIL tmo_data: got %h want 0", d); end
        tests_run++; if (t !== 1'b1) begin tests_failed++; $display("FAIL tmo_flag: got %b want 1", t); end
        tests_run++; if (c != 18) begin tests_failed++; $display("FAIL tmo_cycles: got %0d want 18", c); end
        repeat (6) step();
        @(negedge clk);
        tests_run++; if (avs_acc_readdata !== '0) begin tests_failed++; $display("FAIL late_rdv_ignored: readdata got %h want 0", avs_acc_readdata); end
        tests_run++; if (avs_acc_waitrequest !== 1'b1) begin tests_failed++; $display("FAIL late_rdv_waitreq: got %b want 1", avs_acc_waitrequest); end
        step();
        rd_lat = 2;
        acc_read(32'h300, 40, d, c, t);
        tests_run++; if (d !== 64'hDEAD_BEEF_CAFE_F00D) begin tests_failed++; $display("FAIL post_tmo_data: got %h want deadbeefcafef00d", d); end
        tests_run++; if (c != 4) begin tests_failed++; $display("FAIL post_tmo_cycles: got %0d want 4", c); end
        tests_run++; if (t !== 1'b1) begin tests_failed++; $display("FAIL tmo_sticky: got %b want 1", t); end
        step();
    endtask

    task automatic test_reset_mid();
        int w, snap;
        rd_lat = 0;
        avs_acc_address = 32'h300; avs_acc_byteenable = 8'hFF; avs_acc_read = 1'b1;
        repeat (4) step();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests_run++; if (avs_acc_waitrequest !== 1'b1 || avs_acc_readdata !== '0) begin tests_failed++; $display("FAIL rst_wait_acc: waitreq %b readdata %h want 1 0", avs_acc_waitrequest, avs_acc_readdata); end
        tests_run++; if (avm_mem_read !== 1'b0 || rd_timeout !== 1'b0) begin tests_failed++; $display("FAIL rst_wait_flags: read %b rd_timeout %b want 0 0", avm_mem_read, rd_timeout); end
        avs_acc_read = 1'b0;
        step();
        rst = 1'b0;
        step();
        avm_mem_waitrequest = 1'b1;
        acc_write(32'h500, 64'h1111, 8'hFF, 2, w);
        acc_write(32'h508, 64'h2222, 8'hFF, 2, w);
        @(negedge clk);
        tests_run++; if (avm_mem_write !== 1'b1 || avm_mem_address !== 32'h500) begin tests_failed++; $display("FAIL rst_fifo_setup: write %b addr %h want 1 500", avm_mem_write, avm_mem_address); end
        #2 rst = 1'b1;
        #1;
        tests_run++; if (avm_mem_write !== 1'b0) begin tests_failed++; $display("FAIL rst_fifo_write: got %b want 0", avm_mem_write); end
        tests_run++; if ({avm_mem_address, avm_mem_writedata, avm_mem_byteenable} !== '0) begin tests_failed++; $display("FAIL rst_fifo_fields: got %h %h %h want 0", avm_mem_address, avm_mem_writedata, avm_mem_byteenable); end
        step();
        rst = 1'b0;
        avm_mem_waitrequest = 1'b0;
        snap = strobe_cnt;
        repeat (6) step();
        tests_run++; if (strobe_cnt != snap) begin tests_failed++; $display("FAIL rst_no_strobes: got %0d accepted strobes want 0", strobe_cnt - snap); end
        @(negedge clk);
        tests_run++; if (avm_mem_write !== 1'b0 || avm_mem_read !== 1'b0) begin tests_failed++; $display("FAIL rst_quiet: write %b read %b want 0 0", avm_mem_write, avm_mem_read); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_read_after_write();
        test_variable_latency();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
